// File: rtl/ddr_cmd_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ddr_cmd_gen_if
//  Purpose  : Command request port of ddr_cmd_gen. It carries the clock-enable
//             request, the valid/ready handshake and the command fields.
//  Revision : 1.0  initial release
// ============================================================================
interface ddr_cmd_gen_if #(
   parameter int DDR_BA_WIDTH = 2,
   parameter int DDR_A_WIDTH  = 12,
   parameter int ROW_WIDTH    = 12,
   parameter int COL_WIDTH    = 10
);
   logic                    cke_req;
   logic                    cmd_valid;
   logic                    cmd_ready;
   logic [2:0]              cmd_op;
   logic [DDR_BA_WIDTH-1:0] cmd_ba;
   logic [ROW_WIDTH-1:0]    cmd_row;
   logic [COL_WIDTH-1:0]    cmd_col;
   logic                    cmd_ap;
   logic [DDR_A_WIDTH-1:0]  cmd_mode;

   // Requester side: the init/control state machines
   modport master (
      output cke_req, cmd_valid, cmd_op, cmd_ba, cmd_row, cmd_col, cmd_ap, cmd_mode,
      input  cmd_ready
   );

   // Command generator side
   modport slave (
      input  cke_req, cmd_valid, cmd_op, cmd_ba, cmd_row, cmd_col, cmd_ap, cmd_mode,
      output cmd_ready
   );
endinterface
`default_nettype wire

// File: rtl/ddr_cmd_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ddr_cmd_gen
//  Purpose  : DDR SDRAM command/address pin generator. Accepts commands on a
//             valid/ready port, tracks open rows per bank, squashes illegal
//             commands and inserts NOPs until the next command is legal.
//  Options  : DDR_CMD_NEGEDGE_EN - retime the pin stage on the falling edge
//             (default: second rising-edge register stage).
//  Revision : 1.0  initial release
// ============================================================================
module ddr_cmd_gen #(
   parameter int DDR_BA_WIDTH = 2,
   parameter int DDR_A_WIDTH  = 12,
   parameter int ROW_WIDTH    = 12,
   parameter int COL_WIDTH    = 10,
   parameter int AP_BIT       = 10,
   parameter int T_RCD        = 3,
   parameter int T_RP         = 3,
   parameter int T_RFC        = 10,
   parameter int T_MRD        = 2,
   parameter int CNT_WIDTH    = 5
) (
   input  logic                           clk,
   input  logic                           reset,
   ddr_cmd_gen_if.slave                   cmd_if,
   output logic [(1<<DDR_BA_WIDTH)-1:0]   bank_open,
   output logic                           err_illegal,
   output logic                           ddr_cke,
   output logic                           ddr_csn,
   output logic                           ddr_rasn,
   output logic                           ddr_casn,
   output logic                           ddr_wen,
   output logic [DDR_BA_WIDTH-1:0]        ddr_ba,
   output logic [DDR_A_WIDTH-1:0]         ddr_add
);

   localparam int NB = 1 << DDR_BA_WIDTH;

   // Operation codes on cmd_op
   localparam logic [2:0] OP_ACTIVE        = 3'd1;
   localparam logic [2:0] OP_READ          = 3'd2;
   localparam logic [2:0] OP_WRITE         = 3'd3;
   localparam logic [2:0] OP_PRECHARGE     = 3'd4;
   localparam logic [2:0] OP_PRECHARGE_ALL = 3'd5;
   localparam logic [2:0] OP_AUTO_REFRESH  = 3'd6;
   localparam logic [2:0] OP_LOAD_MODE     = 3'd7;

   // {csn, rasn, casn, wen} pin patterns
   localparam logic [3:0] PIN_INHIBIT = 4'b1111;
   localparam logic [3:0] PIN_NOP     = 4'b0111;
   localparam logic [3:0] PIN_ACTIVE  = 4'b0011;
   localparam logic [3:0] PIN_READ    = 4'b0101;
   localparam logic [3:0] PIN_WRITE   = 4'b0100;
   localparam logic [3:0] PIN_PRE     = 4'b0010;
   localparam logic [3:0] PIN_AREF    = 4'b0001;
   localparam logic [3:0] PIN_LMR     = 4'b0000;

   // Guard loads: T_x - 1 idle cycles after the issuing edge
   localparam logic [CNT_WIDTH-1:0] GUARD_RCD = CNT_WIDTH'(T_RCD - 1);
   localparam logic [CNT_WIDTH-1:0] GUARD_RP  = CNT_WIDTH'(T_RP - 1);
   localparam logic [CNT_WIDTH-1:0] GUARD_RFC = CNT_WIDTH'(T_RFC - 1);
   localparam logic [CNT_WIDTH-1:0] GUARD_MRD = CNT_WIDTH'(T_MRD - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_READY = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t                  state_q,     state_d;
   logic [CNT_WIDTH-1:0]    cnt_q,       cnt_d;
   logic [NB-1:0]           bank_open_q, bank_open_d;
   logic                    err_q,       err_d;
   logic                    cke_q,       cke_d;
   logic [3:0]              cmd_q,       cmd_d;
   logic [DDR_BA_WIDTH-1:0] ba_q,        ba_d;
   logic [DDR_A_WIDTH-1:0]  add_q,       add_d;

   logic                    pin_cke_q;
   logic [3:0]              pin_cmd_q;
   logic [DDR_BA_WIDTH-1:0] pin_ba_q;
   logic [DDR_A_WIDTH-1:0]  pin_add_q;

   // Decoded view of the command currently offered on the port
   logic [3:0]              dec_cmd;
   logic [DDR_BA_WIDTH-1:0] dec_ba;
   logic [DDR_A_WIDTH-1:0]  dec_add;
   logic [CNT_WIDTH-1:0]    dec_guard;
   logic                    dec_legal;
   logic [NB-1:0]           dec_open;
   logic [DDR_A_WIDTH-1:0]  col_add;

   // ready depends only on the FSM state, never on cmd_valid
   assign cmd_if.cmd_ready = (state_q == ST_READY);

   // Encode the offered command, check legality against the open-bank map
   always_comb begin
      dec_cmd   = PIN_NOP;
      dec_ba    = '1;
      dec_add   = '1;
      dec_guard = '0;
      dec_legal = 1'b1;
      dec_open  = bank_open_q;
      col_add   = '0;
      col_add[COL_WIDTH-1:0] = cmd_if.cmd_col;
      col_add[AP_BIT]        = cmd_if.cmd_ap;
      case (cmd_if.cmd_op)
         OP_ACTIVE: begin
            if (bank_open_q[cmd_if.cmd_ba]) begin
               dec_legal = 1'b0;
            end else begin
               dec_cmd   = PIN_ACTIVE;
               dec_ba    = cmd_if.cmd_ba;
               dec_add   = '0;
               dec_add[ROW_WIDTH-1:0] = cmd_if.cmd_row;
               dec_guard = GUARD_RCD;
               dec_open[cmd_if.cmd_ba] = 1'b1;
            end
         end
         OP_READ, OP_WRITE: begin
            if (!bank_open_q[cmd_if.cmd_ba]) begin
               dec_legal = 1'b0;
            end else begin
               dec_cmd = (cmd_if.cmd_op == OP_READ) ? PIN_READ : PIN_WRITE;
               dec_ba  = cmd_if.cmd_ba;
               dec_add = col_add;
               // auto-precharge closes the row once the burst is issued
               if (cmd_if.cmd_ap) begin
                  dec_open[cmd_if.cmd_ba] = 1'b0;
               end
            end
         end
         OP_PRECHARGE: begin
            dec_cmd   = PIN_PRE;
            dec_ba    = cmd_if.cmd_ba;
            dec_add   = '0;
            dec_guard = GUARD_RP;
            dec_open[cmd_if.cmd_ba] = 1'b0;
         end
         OP_PRECHARGE_ALL: begin
            dec_cmd   = PIN_PRE;
            dec_add   = '0;
            dec_add[AP_BIT] = 1'b1;
            dec_guard = GUARD_RP;
            dec_open  = '0;
         end
         OP_AUTO_REFRESH: begin
            if (|bank_open_q) begin
               dec_legal = 1'b0;
            end else begin
               dec_cmd   = PIN_AREF;
               dec_guard = GUARD_RFC;
            end
         end
         OP_LOAD_MODE: begin
            if (|bank_open_q) begin
               dec_legal = 1'b0;
            end else begin
               dec_cmd   = PIN_LMR;
               dec_ba    = cmd_if.cmd_ba;
               dec_add   = cmd_if.cmd_mode;
               dec_guard = GUARD_MRD;
            end
         end
         default: begin
            // NOP: idle encoding, no guard
         end
      endcase
   end

   // Next-state logic for the FSM, guard counter, bank map and command register
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bank_open_d = bank_open_q;
      err_d       = 1'b0;
      cke_d       = 1'b1;
      cmd_d       = PIN_NOP;
      ba_d        = '1;
      add_d       = '1;
      if (!cmd_if.cke_req) begin
         // Losing cke_req wins over everything, including a command offered
         // in the same cycle; any pending guard is dropped.
         state_d = ST_OFF;
         cnt_d   = '0;
         cke_d   = 1'b0;
         cmd_d   = PIN_INHIBIT;
      end else begin
         case (state_q)
            ST_OFF: begin
               state_d = ST_READY;
            end
            ST_READY: begin
               if (cmd_if.cmd_valid) begin
                  cmd_d       = dec_cmd;
                  ba_d        = dec_ba;
                  add_d       = dec_add;
                  bank_open_d = dec_open;
                  err_d       = !dec_legal;
                  if (dec_guard != '0) begin
                     state_d = ST_WAIT;
                     cnt_d   = dec_guard;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt_q <= CNT_ONE) begin
                  state_d = ST_READY;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            default: begin
               state_d = ST_OFF;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Core state and internal command register, updated on the accepting edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_OFF;
         cnt_q       <= '0;
         bank_open_q <= '0;
         err_q       <= 1'b0;
         cke_q       <= 1'b0;
         cmd_q       <= PIN_INHIBIT;
         ba_q        <= '1;
         add_q       <= '1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bank_open_q <= bank_open_d;
         err_q       <= err_d;
         cke_q       <= cke_d;
         cmd_q       <= cmd_d;
         ba_q        <= ba_d;
         add_q       <= add_d;
      end
   end

`ifdef DDR_CMD_NEGEDGE_EN
   // Pin stage on the falling edge centres command/address on the DDR clock
   always_ff @(negedge clk or posedge reset) begin
`else
   // Pin stage on the next rising edge: one full cycle of pin latency
   always_ff @(posedge clk or posedge reset) begin
`endif
      if (reset) begin
         pin_cke_q <= 1'b0;
         pin_cmd_q <= PIN_INHIBIT;
         pin_ba_q  <= '1;
         pin_add_q <= '1;
      end else begin
         pin_cke_q <= cke_q;
         pin_cmd_q <= cmd_q;
         pin_ba_q  <= ba_q;
         pin_add_q <= add_q;
      end
   end

   assign bank_open   = bank_open_q;
   assign err_illegal = err_q;
   assign ddr_cke     = pin_cke_q;
   assign ddr_csn     = pin_cmd_q[3];
   assign ddr_rasn    = pin_cmd_q[2];
   assign ddr_casn    = pin_cmd_q[1];
   assign ddr_wen     = pin_cmd_q[0];
   assign ddr_ba      = pin_ba_q;
   assign ddr_add     = pin_add_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr_cmd_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ddr_cmd_gen
//  Purpose  : Directed self-checking bench for ddr_cmd_gen (default params).
//             Pins are sampled 1 ns after the edge following acceptance,
//             which observes the issued command in either pin-stage build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ddr_cmd_gen;

   localparam logic [2:0] OP_NOP = 3'd0, OP_ACT = 3'd1, OP_RD = 3'd2, OP_WR = 3'd3,
                          OP_PRE = 3'd4, OP_PREA = 3'd5, OP_AREF = 3'd6, OP_LMR = 3'd7;

   // {cke, csn, rasn, casn, wen}
   localparam logic [4:0] P_INH  = 5'b01111;
   localparam logic [4:0] P_NOP  = 5'b10111;
   localparam logic [4:0] P_ACT  = 5'b10011;
   localparam logic [4:0] P_RD   = 5'b10101;
   localparam logic [4:0] P_PRE  = 5'b10010;
   localparam logic [4:0] P_AREF = 5'b10001;
   localparam logic [4:0] P_LMR  = 5'b10000;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  bank_open;
   logic        err_illegal;
   logic        ddr_cke, ddr_csn, ddr_rasn, ddr_casn, ddr_wen;
   logic [1:0]  ddr_ba;
   logic [11:0] ddr_add;
   logic [4:0]  pins;

   int n_checks = 0;
   int n_fail   = 0;
   int lows;

   assign pins = {ddr_cke, ddr_csn, ddr_rasn, ddr_casn, ddr_wen};

   always #5 clk = ~clk;

   ddr_cmd_gen_if #(.DDR_BA_WIDTH(2), .DDR_A_WIDTH(12), .ROW_WIDTH(12), .COL_WIDTH(10)) cmd_if ();

   ddr_cmd_gen dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_if      (cmd_if),
      .bank_open   (bank_open),
      .err_illegal (err_illegal),
      .ddr_cke     (ddr_cke),
      .ddr_csn     (ddr_csn),
      .ddr_rasn    (ddr_rasn),
      .ddr_casn    (ddr_casn),
      .ddr_wen     (ddr_wen),
      .ddr_ba      (ddr_ba),
      .ddr_add     (ddr_add)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bounded wait for cmd_ready; an expired bound shows up as a failed check
   task automatic wait_ready(input string tag);
      for (int i = 0; i < 32 && !cmd_if.cmd_ready; i++) tick();
      chk(tag, {31'd0, cmd_if.cmd_ready}, 32'd1);
   endtask

   // Present one command once ready, return 1 ns after the accepting edge
   task automatic send(input logic [2:0] op, input logic [1:0] ba, input logic [11:0] row,
                       input logic [9:0] col, input logic ap, input logic [11:0] mode);
      wait_ready("ready_before_send");
      cmd_if.cmd_op    = op;
      cmd_if.cmd_ba    = ba;
      cmd_if.cmd_row   = row;
      cmd_if.cmd_col   = col;
      cmd_if.cmd_ap    = ap;
      cmd_if.cmd_mode  = mode;
      cmd_if.cmd_valid = 1'b1;
      tick();
      cmd_if.cmd_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset            = 1'b1;
      cmd_if.cke_req   = 1'b1;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_op    = OP_NOP;
      cmd_if.cmd_ba    = 2'd0;
      cmd_if.cmd_row   = 12'd0;
      cmd_if.cmd_col   = 10'd0;
      cmd_if.cmd_ap    = 1'b0;
      cmd_if.cmd_mode  = 12'd0;

      // Reset state with cke_req already high
      tick(); tick();
      chk("rst_pins",      pins,               P_INH);
      chk("rst_ba",        ddr_ba,             2'b11);
      chk("rst_add",       ddr_add,            12'hFFF);
      chk("rst_ready",     cmd_if.cmd_ready,   1'b0);
      chk("rst_bank_open", bank_open,          4'b0000);
      chk("rst_err",       err_illegal,        1'b0);

      reset = 1'b0;
      tick();
      chk("post_rst_ready", cmd_if.cmd_ready, 1'b1);
      tick();
      chk("post_rst_pins",  pins,             P_NOP);

      // ACTIVE ba=2 row=0x5A3, READ ba=2 col=7 ap=1 held valid behind it
      cmd_if.cmd_op = OP_ACT; cmd_if.cmd_ba = 2'd2; cmd_if.cmd_row = 12'h5A3;
      cmd_if.cmd_valid = 1'b1;
      tick();                                           // ACTIVE accepted
      cmd_if.cmd_op = OP_RD; cmd_if.cmd_col = 10'h007; cmd_if.cmd_ap = 1'b1;
      chk("act_bank_open", bank_open,        4'b0100);
      chk("act_ready0",    cmd_if.cmd_ready, 1'b0);
      tick();
      chk("act_pins",      pins,             P_ACT);
      chk("act_ba",        ddr_ba,           2'd2);
      chk("act_add",       ddr_add,          12'h5A3);
      chk("act_ready1",    cmd_if.cmd_ready, 1'b0);
      tick();
      chk("act_ready2",    cmd_if.cmd_ready, 1'b1);
      chk("rd_not_yet",    bank_open,        4'b0100);
      tick();                                           // READ accepted, 3 edges after ACTIVE
      cmd_if.cmd_valid = 1'b0;
      chk("rd_bank_open",  bank_open,        4'b0000);
      chk("rd_ready",      cmd_if.cmd_ready, 1'b1);
      tick();
      chk("rd_pins",       pins,             P_RD);
      chk("rd_ba",         ddr_ba,           2'd2);
      chk("rd_add",        ddr_add,          12'h407);

      // READ to closed bank 1 is squashed
      cmd_if.cmd_op = OP_RD; cmd_if.cmd_ba = 2'd1; cmd_if.cmd_ap = 1'b0;
      cmd_if.cmd_valid = 1'b1;
      tick();
      cmd_if.cmd_valid = 1'b0;
      chk("ill_err",       err_illegal,      1'b1);
      chk("ill_bank_open", bank_open,        4'b0000);
      chk("ill_ready",     cmd_if.cmd_ready, 1'b1);
      tick();
      chk("ill_err_clear", err_illegal,      1'b0);
      chk("ill_pins",      pins,             P_NOP);

      // AUTO_REFRESH, LOAD_MODE held valid behind it
      cmd_if.cmd_op = OP_AREF; cmd_if.cmd_valid = 1'b1;
      tick();                                           // AUTO_REFRESH accepted
      cmd_if.cmd_op = OP_LMR; cmd_if.cmd_ba = 2'd0; cmd_if.cmd_mode = 12'h033;
      lows = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 1) begin
            chk("aref_pins", pins,    P_AREF);
            chk("aref_add",  ddr_add, 12'hFFF);
         end
         if (cmd_if.cmd_ready) break;
         lows++;
         tick();
      end
      chk("aref_low_cycles", lows, 9);
      tick();                                           // LOAD_MODE accepted
      cmd_if.cmd_valid = 1'b0;
      chk("lmr_err",       err_illegal,      1'b0);
      chk("lmr_ready",     cmd_if.cmd_ready, 1'b0);
      tick();
      chk("lmr_pins",      pins,             P_LMR);
      chk("lmr_add",       ddr_add,          12'h033);
      chk("lmr_ready1",    cmd_if.cmd_ready, 1'b1);

      // Open banks 0 and 3, try a second ACTIVE to bank 3, then PRECHARGE_ALL
      send(OP_ACT, 2'd0, 12'h001, 10'd0, 1'b0, 12'd0);
      send(OP_ACT, 2'd3, 12'h002, 10'd0, 1'b0, 12'd0);
      chk("two_open",      bank_open,        4'b1001);
      send(OP_ACT, 2'd3, 12'h003, 10'd0, 1'b0, 12'd0);
      chk("act_open_err",  err_illegal,      1'b1);
      chk("act_open_map",  bank_open,        4'b1001);
      send(OP_PREA, 2'd1, 12'd0, 10'd0, 1'b0, 12'd0);
      chk("prea_bank_open", bank_open,       4'b0000);
      chk("prea_ready0",   cmd_if.cmd_ready, 1'b0);
      tick();
      chk("prea_pins",     pins,             P_PRE);
      chk("prea_ba",       ddr_ba,           2'b11);
      chk("prea_add",      ddr_add,          12'h400);
      chk("prea_ready1",   cmd_if.cmd_ready, 1'b0);
      tick();
      chk("prea_ready2",   cmd_if.cmd_ready, 1'b1);

      // cke_req dropped during the refresh guard
      send(OP_AREF, 2'd0, 12'd0, 10'd0, 1'b0, 12'd0);
      tick(); tick();
      chk("aref2_ready",   cmd_if.cmd_ready, 1'b0);
      cmd_if.cke_req = 1'b0;
      tick();
      chk("off_ready",     cmd_if.cmd_ready, 1'b0);
      tick();
      chk("off_pins",      pins,             P_INH);
      cmd_if.cke_req = 1'b1;
      tick();
      chk("back_ready",    cmd_if.cmd_ready, 1'b1);
      tick();
      chk("back_pins",     pins,             P_NOP);

      // Asynchronous reset in the middle of a T_RCD wait
      send(OP_ACT, 2'd1, 12'h0AA, 10'd0, 1'b0, 12'd0);
      chk("pre_rst_open",  bank_open,        4'b0010);
      tick();
      reset = 1'b1;
      #1;
      chk("arst_pins",     pins,             P_INH);
      chk("arst_add",      ddr_add,          12'hFFF);
      chk("arst_ready",    cmd_if.cmd_ready, 1'b0);
      chk("arst_open",     bank_open,        4'b0000);
      tick();
      reset = 1'b0;
      tick();
      chk("rel_ready",     cmd_if.cmd_ready, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
